// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, flag width, FSM states.
package alu_pkg;

   localparam int FLAG_W = 4;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_SUB = 4'h1;
   localparam logic [3:0] OP_AND = 4'h2;
   localparam logic [3:0] OP_OR  = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_MOV = 4'hF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   function automatic logic is_mov(input logic [3:0] op);
      return op == OP_MOV;
   endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command and response handshake bundle between the issuing controller and the sequencer.
interface alu_sequencer_if
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IDX_W = 2
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [3:0]        cmd_op;
   logic [IDX_W-1:0]  cmd_dst;
   logic [IDX_W-1:0]  cmd_srca;
   logic [IDX_W-1:0]  cmd_srcb;
   logic              cmd_use_imm;
   logic [WIDTH-1:0]  cmd_imm;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [WIDTH-1:0]  rsp_data;
   logic [FLAG_W-1:0] rsp_flag;

   modport master (
      output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_use_imm, cmd_imm,
      input  cmd_ready,
      input  rsp_valid, rsp_data, rsp_flag,
      output rsp_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_use_imm, cmd_imm,
      output cmd_ready,
      output rsp_valid, rsp_data, rsp_flag,
      input  rsp_ready
   );
endinterface

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: two asynchronous read ports, one synchronous write port.
module alu_regfile #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   parameter int IDX_W = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IDX_W-1:0] raddr_a_i,
   output logic [WIDTH-1:0] rdata_a_o,
   input  logic [IDX_W-1:0] raddr_b_i,
   output logic [WIDTH-1:0] rdata_b_o,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [WIDTH-1:0] wdata_i
);

   logic [WIDTH-1:0] rf_q [NREGS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else if (we_i) begin
         rf_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = rf_q[raddr_a_i];
   assign rdata_b_o = rf_q[raddr_b_i];

endmodule

// File: rtl/alu_sequencer.sv
// Accepts one register-file command at a time, drives the external ALU for one cycle,
// writes the result back and holds it on the response handshake until consumed.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   parameter int IDX_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   alu_sequencer_if.slave    bus,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [3:0]        alu_sel,
   input  logic [WIDTH-1:0]  alu_out,
   input  logic [FLAG_W-1:0] alu_flag,
   output logic              busy
);

   state_e            state_q;
   logic [WIDTH-1:0]  a_q, b_q;
   logic [3:0]        sel_q;
   logic [IDX_W-1:0]  dst_q;
   logic [FLAG_W-1:0] flag_q;
   logic              rsp_valid_q;
   logic [WIDTH-1:0]  rsp_data_q;

   logic [WIDTH-1:0]  rd_a, rd_b;
   logic [WIDTH-1:0]  wb_data_d;
   logic [FLAG_W-1:0] wb_flag_d;
   logic              wb_en;

   alu_regfile #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .IDX_W (IDX_W)
   ) u_rf (
      .clk       (clk),
      .rst       (rst),
      .raddr_a_i (bus.cmd_srca),
      .rdata_a_o (rd_a),
      .raddr_b_i (bus.cmd_srcb),
      .rdata_b_o (rd_b),
      .we_i      (wb_en),
      .waddr_i   (dst_q),
      .wdata_i   (wb_data_d)
   );

   // MOV bypasses the ALU entirely and leaves the flags untouched.
   always_comb begin
      wb_data_d = alu_out;
      wb_flag_d = alu_flag;
      if (is_mov(sel_q)) begin
         wb_data_d = b_q;
         wb_flag_d = flag_q;
      end
   end

   assign wb_en = (state_q == EXEC);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sel_q       <= '0;
         dst_q       <= '0;
         flag_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.cmd_valid) begin
                  a_q     <= rd_a;
                  b_q     <= bus.cmd_use_imm ? bus.cmd_imm : rd_b;
                  sel_q   <= bus.cmd_op;
                  dst_q   <= bus.cmd_dst;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               flag_q      <= wb_flag_d;
               rsp_data_q  <= wb_data_d;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // flag_q only changes on the writeback edge, so it doubles as the response flag register.
   assign bus.rsp_flag  = flag_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.cmd_ready = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign alu_a         = a_q;
   assign alu_b         = b_q;
   assign alu_sel       = sel_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer with a behavioural 8-bit ALU and a response scoreboard.
module tb_alu_sequencer;
   import alu_pkg::*;

   localparam int WIDTH = 8;
   localparam int NREGS = 4;
   localparam int IDX_W = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   alu_sequencer_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

   logic [WIDTH-1:0]  alu_a, alu_b, alu_out;
   logic [3:0]        alu_sel;
   logic [FLAG_W-1:0] alu_flag;
   logic              busy;

   alu_sequencer #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_sel  (alu_sel),
      .alu_out  (alu_out),
      .alu_flag (alu_flag),
      .busy     (busy)
   );

   // ALU flags: [0] zero, [1] carry/borrow, [2] negative, [3] signed overflow
   logic [WIDTH:0] alu_wide;
   logic           alu_v;
   always_comb begin
      alu_wide = '0;
      alu_v    = 1'b0;
      case (alu_sel)
         OP_ADD: begin
            alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
            alu_v    = (alu_a[7] == alu_b[7]) && (alu_wide[7] != alu_a[7]);
         end
         OP_SUB: begin
            alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
            alu_v    = (alu_a[7] != alu_b[7]) && (alu_wide[7] != alu_a[7]);
         end
         OP_AND:  alu_wide = {1'b0, alu_a & alu_b};
         OP_OR:   alu_wide = {1'b0, alu_a | alu_b};
         OP_XOR:  alu_wide = {1'b0, alu_a ^ alu_b};
         default: alu_wide = {1'b0, alu_a};
      endcase
   end
   assign alu_out  = alu_wide[7:0];
   assign alu_flag = {alu_v, alu_wide[7], alu_wide[8], (alu_wide[7:0] == 8'h00)};

   typedef struct {
      logic [3:0]       op;
      logic [IDX_W-1:0] dst, sa, sb;
      logic             use_imm;
      logic [7:0]       imm;
      logic [7:0]       ea, eb, ed;
      logic [3:0]       ef;
   } vec_t;

   typedef struct {
      logic [7:0]       ed;
      logic [3:0]       ef;
      logic [IDX_W-1:0] dst;
   } exp_t;

   exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic drive_cmd(input vec_t v);
      exp_t e;
      bus.cmd_valid   = 1'b1;
      bus.cmd_op      = v.op;
      bus.cmd_dst     = v.dst;
      bus.cmd_srca    = v.sa;
      bus.cmd_srcb    = v.sb;
      bus.cmd_use_imm = v.use_imm;
      bus.cmd_imm     = v.imm;
      e.ed = v.ed; e.ef = v.ef; e.dst = v.dst;
      exp_q.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 32'd1, 32'd0);
         return;
      end
      e = exp_q.pop_front();
      chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(e.ed));
      chk({tag, "_rsp_flag"}, 32'(bus.rsp_flag), 32'(e.ef));
      @(negedge clk);
      chk({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_rf_dst"}, 32'(dut.u_rf.rf_q[e.dst]), 32'(e.ed));
   endtask

   // Entry and exit at a falling edge; rsp_ready held high.
   task automatic run_vec(input vec_t v, input string tag);
      int n;
      drive_cmd(v);
      n = 0;
      while (!bus.cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) chk({tag, "_accept_timeout"}, 32'd1, 32'd0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      chk({tag, "_exec_a"}, 32'(alu_a), 32'(v.ea));
      chk({tag, "_exec_b"}, 32'(alu_b), 32'(v.eb));
      chk({tag, "_exec_sel"}, 32'(alu_sel), 32'(v.op));
      chk({tag, "_exec_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      chk({tag, "_latency"}, 32'(bus.rsp_valid), 32'd1);
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      pop_check(tag);
   endtask

   vec_t tbl[10];
   vec_t bp_sub, bp_mov, rst_add;
   logic [7:0] hold_data;
   logic [3:0] hold_flag;

   initial begin
      //          op      dst sa sb imm imm    ea     eb     ed     ef
      tbl[0] = '{OP_MOV, 0, 0, 0, 1, 8'hC1, 8'h00, 8'hC1, 8'hC1, 4'h0};
      tbl[1] = '{OP_MOV, 1, 1, 0, 1, 8'h0F, 8'h00, 8'h0F, 8'h0F, 4'h0};
      tbl[2] = '{OP_ADD, 2, 0, 1, 0, 8'h00, 8'hC1, 8'h0F, 8'hD0, 4'h4};
      tbl[3] = '{OP_ADD, 0, 0, 0, 0, 8'h00, 8'h0F, 8'h0F, 8'h1E, 4'h0};
      tbl[4] = '{OP_AND, 1, 0, 0, 1, 8'hF0, 8'h1E, 8'hF0, 8'h10, 4'h0};
      tbl[5] = '{OP_ADD, 3, 0, 0, 1, 8'hE2, 8'h1E, 8'hE2, 8'h00, 4'h3};
      tbl[6] = '{OP_MOV, 1, 1, 0, 1, 8'h80, 8'h10, 8'h80, 8'h80, 4'h3};
      tbl[7] = '{OP_ADD, 2, 1, 1, 0, 8'h00, 8'h80, 8'h80, 8'h00, 4'hB};
      tbl[8] = '{OP_OR,  3, 0, 1, 0, 8'h00, 8'h1E, 8'h80, 8'h9E, 4'h4};
      tbl[9] = '{OP_SUB, 0, 1, 0, 0, 8'h00, 8'h80, 8'h1E, 8'h62, 4'h8};
      bp_sub  = '{OP_SUB, 3, 0, 0, 1, 8'hFF, 8'hC1, 8'hFF, 8'hC2, 4'h6};
      bp_mov  = '{OP_MOV, 0, 0, 0, 1, 8'h0F, 8'hC1, 8'h0F, 8'h0F, 4'h6};
      rst_add = '{OP_ADD, 2, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'h0};

      rst = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_dst = '0; bus.cmd_srca = '0;
      bus.cmd_srcb = '0; bus.cmd_use_imm = 1'b0; bus.cmd_imm = '0; bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("rst_alu", {8'h0, alu_a, alu_b, 4'h0, alu_sel}, 32'd0);
         chk("rst_rsp_flag", 32'(bus.rsp_flag), 32'd0);
         rst = (r == 0);
      end
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 3; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Backpressure: response held for five cycles while a second command waits.
      drive_cmd(bp_sub);
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("bp_exec_a", 32'(alu_a), 32'hC1);
      chk("bp_exec_b", 32'(alu_b), 32'hFF);
      chk("bp_exec_sel", 32'(alu_sel), 32'(OP_SUB));
      drive_cmd(bp_mov);
      @(negedge clk);
      chk("bp_latency", 32'(bus.rsp_valid), 32'd1);
      hold_data = bus.rsp_data;
      hold_flag = bus.rsp_flag;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
         chk("bp_hold_data", 32'(bus.rsp_data), 32'(hold_data));
         chk("bp_hold_flag", 32'(bus.rsp_flag), 32'(hold_flag));
         chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         chk("bp_not_accepted", 32'(alu_sel), 32'(OP_SUB));
      end
      bus.rsp_ready = 1'b1;
      pop_check("bp_sub");
      chk("bp_idle_ready", 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("bp2_exec_a", 32'(alu_a), 32'hC1);
      chk("bp2_exec_b", 32'(alu_b), 32'h0F);
      chk("bp2_exec_sel", 32'(alu_sel), 32'(OP_MOV));
      @(negedge clk);
      chk("bp2_latency", 32'(bus.rsp_valid), 32'd1);
      pop_check("bp_mov");

      for (int i = 3; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Reset while the command is in EXEC: no writeback, everything back to reset values.
      bus.rsp_ready = 1'b0;
      drive_cmd(rst_add);
      void'(exp_q.pop_back());
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk("rexec_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("rexec_busy_clr", 32'(busy), 32'd0);
      chk("rexec_alu_clr", {8'h0, alu_a, alu_b, 4'h0, alu_sel}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rexec_no_rsp", 32'(bus.rsp_valid), 32'd0);
         chk("rexec_rf2", 32'(dut.u_rf.rf_q[2]), 32'd0);
         chk("rexec_idle", 32'(bus.cmd_ready), 32'd1);
      end
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
